// File: rtl/tmds_pkg.sv
// Shared types, symbol tables and helpers for the TMDS lane encoder.
// Token tables are written bit9..bit0; index is the control pair / nibble / lane.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_VIDEO = 2'd0,
    MODE_CTRL  = 2'd1,
    MODE_TERC4 = 2'd2,
    MODE_GUARD = 2'd3
  } mode_t;

  localparam logic [9:0] CTRL_TOK [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_TOK [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Video guard band differs only on the green lane.
  localparam logic [9:0] GUARD_TOK [3] = '{
    10'b1011001100, 10'b0100110011, 10'b1011001100
  };

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One TMDS lane: transition-minimising stage, then DC-balancing / token stage.
// Two register stages; every cycle carries a symbol, no flow control.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  mode_t      in_mode,
  input  logic [7:0] in_data,
  input  logic [1:0] in_ctrl,
  input  logic [3:0] in_terc,
  output logic [9:0] tmds
);

  logic [3:0] n1_in;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [8:0] qm_q;
  mode_t      mode_q;
  logic [1:0] ctrl_q;
  logic [3:0] terc_q;

  always_comb begin
    n1_in    = popcnt8(in_data);
    use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !in_data[0]);
    qm_d     = '0;
    qm_d[0]  = in_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ in_data[i]) : (qm_d[i-1] ^ in_data[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_q   <= '0;
      mode_q <= MODE_CTRL;
      ctrl_q <= '0;
      terc_q <= '0;
    end else begin
      qm_q   <= qm_d;
      mode_q <= in_mode;
      ctrl_q <= in_ctrl;
      terc_q <= in_terc;
    end
  end

  logic [3:0]        n1_q;
  logic              q8;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_nxt;
  logic signed [4:0] cnt_d;
  logic signed [4:0] cnt_q;
  logic [9:0]        tmds_d;
  logic [9:0]        tmds_q;

  // Six-bit arithmetic keeps N1-N0 (+-8) and the +-2 correction from wrapping.
  always_comb begin
    n1_q    = popcnt8(qm_q[7:0]);
    q8      = qm_q[8];
    diff    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    cnt_ext = {cnt_q[4], cnt_q};
    cnt_nxt = '0;
    tmds_d  = CTRL_TOK[0];
    case (mode_q)
      MODE_VIDEO: begin
        if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
          tmds_d  = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_nxt = q8 ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if ((!cnt_q[4] && (diff > 6'sd0)) || (cnt_q[4] && (diff < 6'sd0))) begin
          tmds_d  = {1'b1, q8, ~qm_q[7:0]};
          cnt_nxt = cnt_ext + (q8 ? 6'sd2 : 6'sd0) - diff;
        end else begin
          tmds_d  = {1'b0, q8, qm_q[7:0]};
          cnt_nxt = cnt_ext - (q8 ? 6'sd0 : 6'sd2) + diff;
        end
      end
      MODE_CTRL:  tmds_d = CTRL_TOK[ctrl_q];
      MODE_TERC4: tmds_d = TERC4_TOK[terc_q];
      MODE_GUARD: tmds_d = GUARD_TOK[CHANNEL];
      default:    tmds_d = CTRL_TOK[0];
    endcase
    cnt_d = cnt_nxt[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmds_q <= CTRL_TOK[0];
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert ((cnt_q <= 5'sd10) && (cnt_q >= -5'sd10));
  end

  assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed + random bench for tmds_encoder (lane 1) against an integer reference model.
module tb_tmds_encoder;
  import tmds_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  mode_t      in_mode;
  logic [7:0] in_data;
  logic [1:0] in_ctrl;
  logic [3:0] in_terc;
  logic [9:0] tmds;

  tmds_encoder #(.CHANNEL(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_mode (in_mode),
    .in_data (in_data),
    .in_ctrl (in_ctrl),
    .in_terc (in_terc),
    .tmds    (tmds)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] CTRL00 = 10'b1101010100;
  logic [9:0] ref_ctrl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] ref_terc [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  logic [9:0] ref_guard = 10'b0100110011;

  typedef struct {
    logic [9:0] exp;
    logic       is_video;
    logic [7:0] din;
    logic       has_lit;
    logic [9:0] lit;
  } exp_t;

  exp_t exp_q[$];
  int   total     = 0;
  int   passed    = 0;
  int   model_cnt = 0;
  int   run_sum   = 0;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // Reference: encode a byte and update the running disparity in plain integers.
  task automatic ref_video(input logic [7:0] d, output logic [9:0] sym);
    int ones, n1, bal, q8i;
    logic xn, inv;
    logic [7:0] qm;
    ones  = $countones(d);
    xn    = (ones > 4) || ((ones == 4) && (d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8i = xn ? 0 : 1;
    n1  = $countones(qm);
    bal = n1 - (8 - n1);
    if ((model_cnt == 0) || (bal == 0)) begin
      inv       = (q8i == 0);
      model_cnt = model_cnt + ((q8i == 1) ? bal : -bal);
    end else if (((model_cnt > 0) && (bal > 0)) || ((model_cnt < 0) && (bal < 0))) begin
      inv       = 1'b1;
      model_cnt = model_cnt + 2 * q8i - bal;
    end else begin
      inv       = 1'b0;
      model_cnt = model_cnt - 2 * (1 - q8i) + bal;
    end
    sym = {inv, (q8i == 1), inv ? ~qm : qm};
  endtask

  // One cycle: drive inputs, clock, then check the symbol of the previous cycle's inputs.
  task automatic step(input mode_t m, input logic [7:0] d, input logic [1:0] c,
                      input logic [3:0] t, input logic has_lit, input logic [9:0] lit);
    exp_t e;
    logic [9:0] sym;
    in_mode = m; in_data = d; in_ctrl = c; in_terc = t;
    case (m)
      MODE_VIDEO: ref_video(d, sym);
      MODE_CTRL:  sym = ref_ctrl[c];
      MODE_TERC4: sym = ref_terc[t];
      default:    sym = ref_guard;
    endcase
    if (m != MODE_VIDEO) model_cnt = 0;
    e.exp = sym; e.is_video = (m == MODE_VIDEO); e.din = d; e.has_lit = has_lit; e.lit = lit;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("tmds", tmds, e.exp);
    if (e.has_lit) chk("token", tmds, e.lit);
    if (e.is_video) begin
      chk("decode", {2'b00, decode(tmds)}, {2'b00, e.din});
      run_sum = run_sum + 2 * $countones(tmds) - 10;
      total++;
      assert ((run_sum <= 10) && (run_sum >= -10)) passed++;
      else $error("FAIL disparity: observed %0d expected within +-10", run_sum);
    end else begin
      run_sum = 0;
    end
  endtask

  task automatic vid(input logic [7:0] d);
    step(MODE_VIDEO, d, 2'b00, 4'h0, 1'b0, 10'h000);
  endtask

  task automatic vid_lit(input logic [7:0] d, input logic [9:0] lit);
    step(MODE_VIDEO, d, 2'b00, 4'h0, 1'b1, lit);
  endtask

  task automatic tok(input mode_t m, input logic [1:0] c, input logic [3:0] t, input logic [9:0] lit);
    step(m, 8'h00, c, t, 1'b1, lit);
  endtask

  task automatic seed_after_reset();
    exp_t e;
    exp_q.delete();
    e.exp = CTRL00; e.is_video = 1'b0; e.din = 8'h00; e.has_lit = 1'b1; e.lit = CTRL00;
    exp_q.push_back(e);
    model_cnt = 0;
    run_sum   = 0;
  endtask

  initial begin
    mode_t m;
    rst_n = 1'b0; in_mode = MODE_CTRL; in_data = 8'h00; in_ctrl = 2'b00; in_terc = 4'h0;

    // Reset state and first outputs after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tmds", tmds, CTRL00);
    rst_n = 1'b1;
    seed_after_reset();
    tok(MODE_CTRL, 2'b00, 4'h0, CTRL00);
    tok(MODE_CTRL, 2'b00, 4'h0, CTRL00);

    // All-zero video run after control period
    vid_lit(8'h00, 10'h100);
    vid_lit(8'h00, 10'h3FF);
    vid_lit(8'h00, 10'h100);
    vid_lit(8'h00, 10'h3FF);

    // Control, TERC4 and guard tokens
    tok(MODE_CTRL, 2'b01, 4'h0, 10'b0010101011);
    tok(MODE_CTRL, 2'b10, 4'h0, 10'b0101010100);
    tok(MODE_CTRL, 2'b11, 4'h0, 10'b1010101011);
    tok(MODE_TERC4, 2'b00, 4'h0, 10'b1010011100);
    tok(MODE_TERC4, 2'b00, 4'hF, 10'b1011000011);
    tok(MODE_GUARD, 2'b00, 4'h0, 10'b0100110011);

    // Disparity cleared by an intervening control symbol
    vid(8'hFF);
    vid(8'hFF);
    tok(MODE_CTRL, 2'b00, 4'h0, CTRL00);
    vid_lit(8'h00, 10'h100);

    // Long random video run
    repeat (10000) vid(8'($urandom_range(0, 255)));

    // Random per-cycle mode switching
    repeat (2000) begin
      m = mode_t'($urandom_range(0, 3));
      step(m, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 1'b0, 10'h000);
    end

    // Asynchronous reset in the middle of a video run
    vid(8'h00);
    vid(8'h00);
    vid(8'h00);
    rst_n = 1'b0;
    #1;
    chk("async_reset", tmds, CTRL00);
    @(posedge clk);
    #1;
    chk("reset_hold", tmds, CTRL00);
    rst_n = 1'b1;
    seed_after_reset();
    vid_lit(8'h00, 10'h100);
    vid_lit(8'h00, 10'h3FF);
    repeat (20) vid(8'($urandom_range(0, 255)));
    tok(MODE_CTRL, 2'b00, 4'h0, CTRL00);
    tok(MODE_CTRL, 2'b00, 4'h0, CTRL00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
